// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order write-back FIFO feeding the integer register file.
// Accepts retiring results over valid/ready, resolves jal (pc+4) at enqueue,
// drains one write per cycle and answers two pending-write queries with
// youngest-entry forwarding.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           result handshake from execute
//   in_addr/in_data             destination index and result data
//   in_jal/in_pc                write in_pc+4 instead of in_data when in_jal=1
//   drain_en                    0 holds the queue (write port busy)
//   rf_wen/rf_waddr/rf_wdata    register file write port (from head entry)
//   q_addr1/2 -> q_hit1/2, q_data1/2   pending-write queries
//   count                       occupied entries (0..DEPTH)
module rf_writeback_queue #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_jal,
  input  logic [DATA_WIDTH-1:0]   in_pc,
  input  logic                    drain_en,
  output logic                    rf_wen,
  output logic [ADDR_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  input  logic [ADDR_WIDTH-1:0]   q_addr1,
  input  logic [ADDR_WIDTH-1:0]   q_addr2,
  output logic                    q_hit1,
  output logic                    q_hit2,
  output logic [DATA_WIDTH-1:0]   q_data1,
  output logic [DATA_WIDTH-1:0]   q_data2,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  not_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [PTR_W-1:0]      idx;

  // Handshake and drain controls
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign rf_wen    = not_empty & drain_en;
  assign rf_waddr  = not_empty ? addr_q[head_q] : '0;
  assign rf_wdata  = not_empty ? data_q[head_q] : '0;
  assign count     = count_q;

  // Writes to x0 complete the handshake but are never queued
  assign push      = in_valid & in_ready & (in_addr != '0);
  assign pop       = rf_wen;
  assign push_data = in_jal ? (in_pc + DATA_WIDTH'(4)) : in_data;

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= push_data;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queries walk oldest to youngest so the youngest match is the one kept
  always_comb begin
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    idx     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((q_addr1 != '0) && (addr_q[idx] == q_addr1)) begin
          q_hit1  = 1'b1;
          q_data1 = data_q[idx];
        end
        if ((q_addr2 != '0) && (addr_q[idx] == q_addr2)) begin
          q_hit2  = 1'b1;
          q_data2 = data_q[idx];
        end
      end
    end
  end

endmodule
